// File: rtl/xm23_dev_pkg.sv
// ---------------------------------------------------------------------------
// xm23_dev_pkg
// Shared definitions for the XM23 device port bank:
//   - bit positions of the fields inside a channel CSR byte
//   - default width of the interrupt priority field
//   - the direction encoding of the CSR IO bit
//   - chan_offset(): byte offset of a channel's CSR from the bank base
// ---------------------------------------------------------------------------
package xm23_dev_pkg;

   localparam int CSR_IE      = 0;
   localparam int CSR_IO      = 1;
   localparam int CSR_DBA     = 2;
   localparam int CSR_OF      = 3;
   localparam int CSR_ENA     = 4;
   localparam int CSR_PRI_LSB = 5;

   localparam int DEF_PRI_W   = 3;

   typedef enum logic {
      DIR_IN  = 1'b0,
      DIR_OUT = 1'b1
   } dev_dir_e;

   // Each channel occupies a CSR/data byte pair, so channel i starts 2*i bytes
   // above the bank base.
   function automatic logic [15:0] chan_offset(input int unsigned idx);
      return 16'(2 * idx);
   endfunction

endpackage

// File: rtl/xm23_dev_channel.sv
// ---------------------------------------------------------------------------
// xm23_dev_channel
// One device channel: CSR byte, data byte, output handshake and the
// interrupt pending bit.
// Ports:
//   Clock, Reset_n      system clock, synchronous active-low reset
//   csr_wr, csr_wdata   bus write to this channel's CSR
//   data_wr, data_wdata bus write to this channel's data register
//   data_rd             bus read of the data register (read side effects)
//   in_valid, in_data   input device byte strobe and byte
//   out_ready           output device accepts the pending byte
//   grant_ack           PIC acknowledged this channel's granted request
//   csr, data           current register contents for the read mux
//   out_valid           output byte pending
//   pending, pri        interrupt pending bit and its priority
// ---------------------------------------------------------------------------
module xm23_dev_channel
   import xm23_dev_pkg::*;
#(
   parameter int PRI_W = DEF_PRI_W
)(
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             csr_wr,
   input  logic [7:0]       csr_wdata,
   input  logic             data_wr,
   input  logic [7:0]       data_wdata,
   input  logic             data_rd,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             out_ready,
   input  logic             grant_ack,
   output logic [7:0]       csr,
   output logic [7:0]       data,
   output logic             out_valid,
   output logic             pending,
   output logic [PRI_W-1:0] pri
);

   logic             ie, ena, dba, of_flag;
   dev_dir_e         io;
   logic [PRI_W-1:0] pri_q;
   logic [7:0]       data_q;
   logic             out_valid_q, pending_q;

   logic             ie_n, ena_n, dba_n, of_n, out_valid_n, pending_n;
   dev_dir_e         io_n;
   logic [PRI_W-1:0] pri_n;
   logic [7:0]       data_n;
   logic             handshake;

   // DBA is never written directly from the bus.
   logic unused_csr_dba;
   assign unused_csr_dba = csr_wdata[CSR_DBA];

   assign handshake = out_valid_q && out_ready;

   // Next-state logic. Device/data events are resolved first, then a CSR
   // write is layered on top so that an IO direction change and the OF
   // write-1-to-clear have the final say over DBA, OF and out_valid.
   always_comb begin
      ie_n        = ie;
      io_n        = io;
      ena_n       = ena;
      pri_n       = pri_q;
      dba_n       = dba;
      of_n        = of_flag;
      data_n      = data_q;
      out_valid_n = out_valid_q;

      if (io == DIR_IN) begin
         if (ena && in_valid) begin
            data_n = in_data;
            dba_n  = 1'b1;
            if (dba && !data_rd) begin
               of_n = 1'b1;
            end
         end else if (data_rd) begin
            dba_n = 1'b0;
            of_n  = 1'b0;
         end
      end else begin
         if (data_wr) begin
            data_n      = data_wdata;
            out_valid_n = 1'b1;
            dba_n       = 1'b0;
            if (!dba && !handshake) begin
               of_n = 1'b1;
            end
         end else if (handshake) begin
            out_valid_n = 1'b0;
            dba_n       = 1'b1;
         end
      end

      if (csr_wr) begin
         ie_n  = csr_wdata[CSR_IE];
         io_n  = dev_dir_e'(csr_wdata[CSR_IO]);
         ena_n = csr_wdata[CSR_ENA];
         pri_n = csr_wdata[CSR_PRI_LSB +: PRI_W];
         if (csr_wdata[CSR_OF]) begin
            of_n = 1'b0;
         end
         if (io == DIR_IN && csr_wdata[CSR_IO]) begin
            dba_n = 1'b1;
         end else if (io == DIR_OUT && !csr_wdata[CSR_IO]) begin
            dba_n       = 1'b0;
            out_valid_n = 1'b0;
         end
      end

      // A fresh DBA rising edge beats an ack on the same cycle, but turning
      // IE off always wins.
      pending_n = pending_q;
      if (grant_ack) begin
         pending_n = 1'b0;
      end
      if (!dba && dba_n && ie && ena) begin
         pending_n = 1'b1;
      end
      if (csr_wr && !csr_wdata[CSR_IE]) begin
         pending_n = 1'b0;
      end
   end

   // Channel state registers; reset abandons any output handshake.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         ie          <= 1'b0;
         io          <= DIR_IN;
         ena         <= 1'b0;
         pri_q       <= '0;
         dba         <= 1'b0;
         of_flag     <= 1'b0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         ie          <= ie_n;
         io          <= io_n;
         ena         <= ena_n;
         pri_q       <= pri_n;
         dba         <= dba_n;
         of_flag     <= of_n;
         data_q      <= data_n;
         out_valid_q <= out_valid_n;
         pending_q   <= pending_n;
      end
   end

   // Pack the CSR fields back into the bus-visible byte.
   always_comb begin
      csr                         = '0;
      csr[CSR_IE]                 = ie;
      csr[CSR_IO]                 = io;
      csr[CSR_DBA]                = dba;
      csr[CSR_OF]                 = of_flag;
      csr[CSR_ENA]                = ena;
      csr[CSR_PRI_LSB +: PRI_W]   = pri_q;
   end

   assign data      = data_q;
   assign out_valid = out_valid_q;
   assign pending   = pending_q;
   assign pri       = pri_q;

endmodule

// File: rtl/xm23_dev_port_bank.sv
// ---------------------------------------------------------------------------
// xm23_dev_port_bank
// Memory-mapped bank of NUM_DEV device channels for the XM23 CPU, plus a
// priority arbiter that presents one interrupt request to the PIC.
// Ports:
//   Clock, Reset_n              system clock, synchronous active-low reset
//   bus_addr/rd/wr/byte/wdata   CPU bus request
//   bus_rdata, bus_rvalid       registered read response (1-cycle latency)
//   bus_hit                     address falls inside the bank
//   dev_in_valid, dev_in_data   input device strobes and bytes
//   dev_out_valid, dev_out_data output bytes pending for devices
//   dev_out_ready               output devices accept their bytes
//   irq_req, irq_vect, irq_pri  granted interrupt request
//   irq_ack                     PIC accepted the granted request
// ---------------------------------------------------------------------------
module xm23_dev_port_bank
   import xm23_dev_pkg::*;
#(
   parameter int          NUM_DEV   = 5,
   parameter logic [15:0] ADDR_BASE = 16'h0000,
   parameter int          PRI_W     = DEF_PRI_W
)(
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic [15:0]            bus_addr,
   input  logic                   bus_rd,
   input  logic                   bus_wr,
   input  logic                   bus_byte,
   input  logic [15:0]            bus_wdata,
   output logic [15:0]            bus_rdata,
   output logic                   bus_rvalid,
   output logic                   bus_hit,
   input  logic [NUM_DEV-1:0]     dev_in_valid,
   input  logic [8*NUM_DEV-1:0]   dev_in_data,
   output logic [NUM_DEV-1:0]     dev_out_valid,
   output logic [8*NUM_DEV-1:0]   dev_out_data,
   input  logic [NUM_DEV-1:0]     dev_out_ready,
   output logic                   irq_req,
   output logic [3:0]             irq_vect,
   output logic [PRI_W-1:0]       irq_pri,
   input  logic                   irq_ack
);

   localparam logic [15:0] SPAN = 16'(2 * NUM_DEV);

   logic [16:0]      addr_diff;
   logic [15:0]      offset;
   logic             is_data, word_even;
   logic [NUM_DEV-1:0] sel, pending;
   logic [7:0]       csr_arr  [NUM_DEV];
   logic [7:0]       data_arr [NUM_DEV];
   logic [PRI_W-1:0] pri_arr  [NUM_DEV];
   logic [15:0]      read_mux;
   logic             win_found;
   logic [3:0]       win_idx;
   logic [PRI_W-1:0] win_pri;

   // The extra top bit catches addresses below the base, which would
   // otherwise wrap into the bank.
   assign addr_diff = {1'b0, bus_addr} - {1'b0, ADDR_BASE};
   assign offset    = addr_diff[15:0];
   assign bus_hit   = !addr_diff[16] && (offset < SPAN);
   assign is_data   = offset[0];
   assign word_even = !bus_byte && !offset[0];

   for (genvar i = 0; i < NUM_DEV; i++) begin : g_chan
      logic grant_ack;

      assign sel[i]    = bus_hit && ({offset[15:1], 1'b0} == chan_offset(i));
      assign grant_ack = irq_ack && irq_req && (irq_vect == 4'(i));

      xm23_dev_channel #(
         .PRI_W (PRI_W)
      ) u_chan (
         .Clock      (Clock),
         .Reset_n    (Reset_n),
         .csr_wr     (bus_wr && sel[i] && !is_data),
         .csr_wdata  (bus_wdata[7:0]),
         .data_wr    (bus_wr && sel[i] && (is_data || word_even)),
         .data_wdata (word_even ? bus_wdata[15:8] : bus_wdata[7:0]),
         .data_rd    (bus_rd && sel[i] && (is_data || word_even)),
         .in_valid   (dev_in_valid[i]),
         .in_data    (dev_in_data[8*i +: 8]),
         .out_ready  (dev_out_ready[i]),
         .grant_ack  (grant_ack),
         .csr        (csr_arr[i]),
         .data       (data_arr[i]),
         .out_valid  (dev_out_valid[i]),
         .pending    (pending[i]),
         .pri        (pri_arr[i])
      );

      assign dev_out_data[8*i +: 8] = data_arr[i];
   end

   // Read mux: an even word access returns data in the high byte and the
   // CSR in the low byte; everything else is a zero-extended single byte.
   always_comb begin
      read_mux = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (sel[i]) begin
            if (word_even) begin
               read_mux = {data_arr[i], csr_arr[i]};
            end else if (is_data) begin
               read_mux = {8'h00, data_arr[i]};
            end else begin
               read_mux = {8'h00, csr_arr[i]};
            end
         end
      end
   end

   // Registered read response; a miss still answers, with zero data.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
      end else begin
         bus_rvalid <= bus_rd;
         if (bus_rd) begin
            bus_rdata <= read_mux;
         end
      end
   end

   // Priority arbiter over the registered pending bits. The strict '>'
   // keeps the lowest index on a priority tie.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_pri   = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (pending[i] && (!win_found || pri_arr[i] > win_pri)) begin
            win_found = 1'b1;
            win_idx   = 4'(i);
            win_pri   = pri_arr[i];
         end
      end
   end

   assign irq_req  = win_found;
   assign irq_vect = win_idx;
   assign irq_pri  = win_pri;

endmodule

// File: tb/tb_xm23_dev_port_bank.sv
// ---------------------------------------------------------------------------
// tb_xm23_dev_port_bank
// Self-checking bench for xm23_dev_port_bank (5 channels, base 16'h0100).
// A table of bus/device vectors walks through reset reads, input channel
// DBA/OF behaviour and output channel setup; hand-written sequences cover
// the output handshake, address misses, interrupt arbitration, the
// read/input collision and reset during a pending output.
// ---------------------------------------------------------------------------
module tb_xm23_dev_port_bank;

   localparam int          NUM_DEV   = 5;
   localparam logic [15:0] ADDR_BASE = 16'h0100;

   logic        clk;
   logic        reset_n;
   logic [15:0] bus_addr;
   logic        bus_rd, bus_wr, bus_byte;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_rvalid, bus_hit;
   logic [4:0]  dev_in_valid;
   logic [39:0] dev_in_data;
   logic [4:0]  dev_out_valid;
   logic [39:0] dev_out_data;
   logic [4:0]  dev_out_ready;
   logic        irq_req;
   logic [3:0]  irq_vect;
   logic [2:0]  irq_pri;
   logic        irq_ack;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        bw;
      logic [15:0] addr;
      logic [15:0] wd;
      logic [4:0]  in_v;
      logic [7:0]  in_d;
      logic        chk_rd;
      logic [15:0] exp_rdata;
      logic        chk_irq;
      logic        exp_req;
      logic [3:0]  exp_vect;
   } vec_t;

   vec_t vecs[$];

   xm23_dev_port_bank #(
      .NUM_DEV   (NUM_DEV),
      .ADDR_BASE (ADDR_BASE),
      .PRI_W     (3)
   ) dut (
      .Clock         (clk),
      .Reset_n       (reset_n),
      .bus_addr      (bus_addr),
      .bus_rd        (bus_rd),
      .bus_wr        (bus_wr),
      .bus_byte      (bus_byte),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_rvalid    (bus_rvalid),
      .bus_hit       (bus_hit),
      .dev_in_valid  (dev_in_valid),
      .dev_in_data   (dev_in_data),
      .dev_out_valid (dev_out_valid),
      .dev_out_data  (dev_out_data),
      .dev_out_ready (dev_out_ready),
      .irq_req       (irq_req),
      .irq_vect      (irq_vect),
      .irq_pri       (irq_pri),
      .irq_ack       (irq_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // One bus cycle: drive at a falling edge, let the DUT sample on the
   // following rising edge, release strobes at the next falling edge.
   task automatic applyStimulus(input logic rd, input logic wr, input logic bw,
                                input logic [15:0] addr, input logic [15:0] wd);
      @(negedge clk);
      bus_rd    = rd;
      bus_wr    = wr;
      bus_byte  = bw;
      bus_addr  = addr;
      bus_wdata = wd;
      @(negedge clk);
      bus_rd = 1'b0;
      bus_wr = 1'b0;
   endtask

   task automatic pulseIn(input logic [4:0] mask, input logic [7:0] d);
      @(negedge clk);
      dev_in_valid = mask;
      dev_in_data  = {5{d}};
      @(negedge clk);
      dev_in_valid = '0;
   endtask

   task automatic pulseAck();
      @(negedge clk);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [15:0] addr, input logic bw,
                            input logic [15:0] exp_v);
      applyStimulus(1'b1, 1'b0, bw, addr, 16'h0000);
      checkOutput({name, "_rvalid"}, 40'(bus_rvalid), 40'(1'b1));
      checkOutput(name, 40'(bus_rdata), 40'(exp_v));
   endtask

   task automatic addVec(input logic rd, input logic wr, input logic bw,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic [4:0] in_v, input logic [7:0] in_d,
                         input logic chk_rd, input logic [15:0] exp_rdata,
                         input logic chk_irq, input logic exp_req, input logic [3:0] exp_vect);
      vec_t v;
      v.rd = rd; v.wr = wr; v.bw = bw; v.addr = addr; v.wd = wd;
      v.in_v = in_v; v.in_d = in_d;
      v.chk_rd = chk_rd; v.exp_rdata = exp_rdata;
      v.chk_irq = chk_irq; v.exp_req = exp_req; v.exp_vect = exp_vect;
      vecs.push_back(v);
   endtask

   initial begin
      reset_n       = 1'b0;
      bus_addr      = '0;
      bus_rd        = 1'b0;
      bus_wr        = 1'b0;
      bus_byte      = 1'b1;
      bus_wdata     = '0;
      dev_in_valid  = '0;
      dev_in_data   = '0;
      dev_out_ready = '0;
      irq_ack       = 1'b0;

      // Reset reads: every CSR and data byte is zero.
      for (int a = 0; a < 2 * NUM_DEV; a++) begin
         addVec(1, 0, 1, ADDR_BASE + 16'(a), 16'h0000, 5'b0, 8'h00, 1, 16'h0000, 1, 0, 4'd0);
      end
      // Ch1 input with IE, ENA, PRI=1.
      addVec(0, 1, 1, 16'h0102, 16'h0031, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 4'd0);
      addVec(0, 0, 1, 16'h0000, 16'h0000, 5'b00010, 8'hA5, 0, 16'h0000, 1, 1, 4'd1);
      addVec(1, 0, 1, 16'h0102, 16'h0000, 5'b00000, 8'h00, 1, 16'h0035, 1, 1, 4'd1);
      addVec(1, 0, 1, 16'h0103, 16'h0000, 5'b00000, 8'h00, 1, 16'h00A5, 0, 0, 4'd0);
      addVec(1, 0, 1, 16'h0102, 16'h0000, 5'b00000, 8'h00, 1, 16'h0031, 0, 0, 4'd0);
      // Ch1 overflow, then OF write-1-to-clear (also drops IE and pending).
      addVec(0, 0, 1, 16'h0000, 16'h0000, 5'b00010, 8'h11, 0, 16'h0000, 0, 0, 4'd0);
      addVec(0, 0, 1, 16'h0000, 16'h0000, 5'b00010, 8'h22, 0, 16'h0000, 0, 0, 4'd0);
      addVec(1, 0, 1, 16'h0102, 16'h0000, 5'b00000, 8'h00, 1, 16'h003D, 0, 0, 4'd0);
      addVec(0, 1, 1, 16'h0102, 16'h0008, 5'b00000, 8'h00, 0, 16'h0000, 1, 0, 4'd0);
      addVec(1, 0, 1, 16'h0102, 16'h0000, 5'b00000, 8'h00, 1, 16'h0004, 0, 0, 4'd0);
      addVec(1, 0, 1, 16'h0103, 16'h0000, 5'b00000, 8'h00, 1, 16'h0022, 0, 0, 4'd0);
      addVec(1, 0, 1, 16'h0102, 16'h0000, 5'b00000, 8'h00, 1, 16'h0000, 0, 0, 4'd0);
      // Ch2 output setup and data write; word and odd-word reads.
      addVec(0, 1, 1, 16'h0104, 16'h0012, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 4'd0);
      addVec(1, 0, 1, 16'h0104, 16'h0000, 5'b00000, 8'h00, 1, 16'h0016, 0, 0, 4'd0);
      addVec(0, 1, 1, 16'h0105, 16'h005A, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 4'd0);
      addVec(1, 0, 1, 16'h0104, 16'h0000, 5'b00000, 8'h00, 1, 16'h0012, 0, 0, 4'd0);
      addVec(1, 0, 0, 16'h0104, 16'h0000, 5'b00000, 8'h00, 1, 16'h5A12, 0, 0, 4'd0);
      addVec(1, 0, 0, 16'h0105, 16'h0000, 5'b00000, 8'h00, 1, 16'h005A, 0, 0, 4'd0);

      repeat (3) @(negedge clk);
      checkOutput("rst_rvalid", 40'(bus_rvalid), 40'(1'b0));
      checkOutput("rst_rdata", 40'(bus_rdata), 40'(16'h0000));
      checkOutput("rst_out_valid", 40'(dev_out_valid), 40'(5'b0));
      checkOutput("rst_irq", {32'h0, irq_req, irq_vect, irq_pri}, 40'h0);
      reset_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         bus_rd       = vecs[k].rd;
         bus_wr       = vecs[k].wr;
         bus_byte     = vecs[k].bw;
         bus_addr     = vecs[k].addr;
         bus_wdata    = vecs[k].wd;
         dev_in_valid = vecs[k].in_v;
         dev_in_data  = {5{vecs[k].in_d}};
         @(negedge clk);
         bus_rd       = 1'b0;
         bus_wr       = 1'b0;
         dev_in_valid = '0;
         checkOutput($sformatf("vec%0d_rvalid", k), 40'(bus_rvalid), 40'(vecs[k].rd));
         if (vecs[k].chk_rd) begin
            checkOutput($sformatf("vec%0d_rdata", k), 40'(bus_rdata), 40'(vecs[k].exp_rdata));
         end
         if (vecs[k].chk_irq) begin
            checkOutput($sformatf("vec%0d_irq", k), {35'h0, irq_req, irq_vect},
                        {35'h0, vecs[k].exp_req, vecs[k].exp_vect});
         end
      end

      // Output handshake on ch2: byte waits while ready is low.
      checkOutput("out_valid_pend", 40'(dev_out_valid), 40'(5'b00100));
      checkOutput("out_data_ch2", 40'(dev_out_data[23:16]), 40'(8'h5A));
      repeat (3) @(negedge clk);
      checkOutput("out_valid_hold", 40'(dev_out_valid[2]), 40'(1'b1));
      dev_out_ready = 5'b00100;
      @(negedge clk);
      dev_out_ready = '0;
      checkOutput("out_valid_done", 40'(dev_out_valid[2]), 40'(1'b0));
      readCheck("ch2_csr_idle", 16'h0104, 1'b1, 16'h0016);

      // Address decode edges and a miss read.
      @(negedge clk);
      bus_addr = 16'h00FF;
      #1 checkOutput("hit_below", 40'(bus_hit), 40'(1'b0));
      bus_addr = 16'h0109;
      #1 checkOutput("hit_last", 40'(bus_hit), 40'(1'b1));
      readCheck("miss_rdata", 16'h010A, 1'b1, 16'h0000);

      // Interrupt arbitration: ch0 PRI=2, ch3 PRI=5.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0051);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0106, 16'h00B1);
      pulseIn(5'b01001, 8'h44);
      checkOutput("irq_two", {32'h0, irq_req, irq_vect, irq_pri}, {32'h0, 1'b1, 4'd3, 3'd5});
      pulseAck();
      checkOutput("irq_after_ack", {32'h0, irq_req, irq_vect, irq_pri}, {32'h0, 1'b1, 4'd0, 3'd2});
      pulseAck();
      checkOutput("irq_empty", {32'h0, irq_req, irq_vect, irq_pri}, 40'h0);

      // A new ch0 event on the same cycle as the ch3 ack must survive.
      readCheck("ch0_data", 16'h0101, 1'b1, 16'h0044);
      readCheck("ch3_data", 16'h0107, 1'b1, 16'h0044);
      pulseIn(5'b01000, 8'h55);
      checkOutput("irq_ch3", {32'h0, irq_req, irq_vect, irq_pri}, {32'h0, 1'b1, 4'd3, 3'd5});
      @(negedge clk);
      irq_ack      = 1'b1;
      dev_in_valid = 5'b00001;
      dev_in_data  = {5{8'h66}};
      @(negedge clk);
      irq_ack      = 1'b0;
      dev_in_valid = '0;
      checkOutput("irq_retained", {32'h0, irq_req, irq_vect, irq_pri}, {32'h0, 1'b1, 4'd0, 3'd2});
      pulseAck();
      checkOutput("irq_cleared", 40'(irq_req), 40'(1'b0));

      // Ch4 input: a read coinciding with a new byte returns the old byte.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0108, 16'h0010);
      pulseIn(5'b10000, 8'h77);
      @(negedge clk);
      bus_rd       = 1'b1;
      bus_byte     = 1'b1;
      bus_addr     = 16'h0109;
      dev_in_valid = 5'b10000;
      dev_in_data  = {5{8'h88}};
      @(negedge clk);
      bus_rd       = 1'b0;
      dev_in_valid = '0;
      checkOutput("collide_rdata", 40'(bus_rdata), 40'(16'h0077));
      readCheck("collide_csr", 16'h0108, 1'b1, 16'h0014);
      readCheck("collide_data", 16'h0109, 1'b1, 16'h0088);

      // Reset while ch2 has an output byte pending, with bus/device noise.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0105, 16'h003C);
      checkOutput("pre_rst_out", 40'(dev_out_valid), 40'(5'b00100));
      @(negedge clk);
      reset_n       = 1'b0;
      bus_wr        = 1'b1;
      bus_rd        = 1'b1;
      bus_addr      = 16'h0104;
      bus_wdata     = 16'h00FF;
      dev_out_ready = '1;
      dev_in_valid  = '1;
      @(negedge clk);
      reset_n       = 1'b1;
      bus_wr        = 1'b0;
      bus_rd        = 1'b0;
      dev_out_ready = '0;
      dev_in_valid  = '0;
      checkOutput("post_rst_out_valid", 40'(dev_out_valid), 40'(5'b0));
      checkOutput("post_rst_out_data", dev_out_data, 40'h0);
      checkOutput("post_rst_bus", {23'h0, bus_rvalid, bus_rdata}, 40'h0);
      checkOutput("post_rst_irq", {32'h0, irq_req, irq_vect, irq_pri}, 40'h0);
      readCheck("post_rst_csr", 16'h0104, 1'b1, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xm23_dev_port_bank.md
Name: xm23_dev_port_bank

Overview:
Parametrised memory-mapped device register bank for the XM23 CPU. It replaces the fixed, ad-hoc dev_mem array with NUM_DEV uniform channels, each a CSR/data byte pair. Every channel enforces DBA/OF semantics for input and output devices. The bank also drives a priority-resolved interrupt request to the PIC. It sits between the CPU MAR/MDR bus logic and the device drivers (timer, kb/scr, traffic lights, pedestrian button).

Parameters:
NUM_DEV, 5, number of device channels (1..8).
ADDR_BASE, 16'h0000, byte address of channel 0 CSR. Channel i CSR is at ADDR_BASE+2i; its data register is at ADDR_BASE+2i+1.
PRI_W, 3, width of the priority field.

Ports:
Clock  in  1  system clock; all state updates on posedge.
Reset_n  in  1  synchronous, active-low reset.
bus_addr  in  16  CPU byte address.
bus_rd  in  1  read strobe, one cycle.
bus_wr  in  1  write strobe, one cycle.
bus_byte  in  1  1=byte access, 0=word access.
bus_wdata  in  16  write data; a byte access uses [7:0].
bus_rdata  out  16  registered read data.
bus_rvalid  out  1  high one cycle after an accepted bus_rd.
bus_hit  out  1  combinational: bus_addr lies inside the bank.
dev_in_valid  in  NUM_DEV  per-channel input byte strobe.
dev_in_data  in  8*NUM_DEV  input bytes; channel i uses [8i+7:8i].
dev_out_valid  out  NUM_DEV  output byte pending.
dev_out_data  out  8*NUM_DEV  output bytes.
dev_out_ready  in  NUM_DEV  device accepts the output byte.
irq_req  out  1  an interrupt is pending.
irq_vect  out  4  channel index of the granted request.
irq_pri  out  PRI_W  priority of the granted request.
irq_ack  in  1  PIC accepted the granted request.

Behaviour:
- Reset (Reset_n=0 at posedge):
  - All CSRs, data registers and pending bits are 0.
  - bus_rdata=0, bus_rvalid=0, dev_out_valid=0, irq_req=0, irq_vect=0, irq_pri=0.
  - Reset overrides any bus or device event in the same cycle. An in-flight output handshake is abandoned.
- CSR layout: [0] IE, [1] IO (0=input, 1=output), [2] DBA, [3] OF, [4] ENA, [7:5] PRI.
- CSR write updates IE, IO, ENA and PRI.
  - DBA is read-only from the bus.
  - OF is write-1-to-clear.
  - An IO change 0->1 sets DBA=1 (output idle). An IO change 1->0 clears DBA and drops dev_out_valid.
- Reads:
  - 1-cycle latency: rdata and rvalid are registered.
  - Reading a CSR has no side effect.
  - Reading a data register returns the pre-edge value. For an input channel it clears DBA and OF on the same edge.
  - Out-of-range address: bus_hit=0, bus_rvalid still pulses, bus_rdata=0, no side effects.
- Word access at an even address covers CSR (low byte) and data (high byte); side effects of both apply. Word access at an odd address is treated as a byte access.
- Input channel (IO=0, ENA=1), on dev_in_valid:
  - data is loaded.
  - If DBA was already 1, OF<=1.
  - DBA<=1.
  - ENA=0: input strobes are ignored.
- Simultaneous input dev_in_valid and CPU data read: the read returns the old byte, the new byte loads, DBA stays 1, OF is unchanged.
- Output channel (IO=1), on CPU data write:
  - data is loaded and dev_out_valid<=1.
  - If DBA was 0 (previous byte unsent), OF<=1 and the new byte replaces the old one.
  - DBA<=0.
  - Handshake: when dev_out_valid and dev_out_ready are both high at posedge, dev_out_valid<=0 and DBA<=1.
- Simultaneous output handshake and CPU data write: the write wins. dev_out_valid stays 1 with the new byte, DBA=0, OF not set.
- Interrupts:
  - A channel's pending bit sets on a DBA 0->1 transition while IE=1 and ENA=1.
  - Pending clears on irq_ack for the granted channel, when IE is written 0, or on reset.
  - Arbiter (combinational from registered pending bits): highest PRI wins; ties go to the lowest index.
  - irq_req = OR of pending. irq_vect and irq_pri hold the winner. When nothing is pending they read 0.
  - An irq_ack while irq_req=0 is ignored. A new pending event in the same cycle as an ack for a different channel is retained.
- Width rule: PRI is compared unsigned. A channel index at or above NUM_DEV never hits.

Decomposition:
- Package xm23_dev_pkg holds:
  - CSR bit index constants: CSR_IE=0, CSR_IO=1, CSR_DBA=2, CSR_OF=3, CSR_ENA=4, CSR_PRI_LSB=5.
  - Default PRI_W.
  - The channel address-offset function.
- Sub-module xm23_dev_channel, instantiated NUM_DEV times, holds one CSR, data register, output handshake and pending bit.
- The top holds address decode, the read mux/register and the priority arbiter.

Test Plan:
1. Reset, then read every address from ADDR_BASE to ADDR_BASE+2*NUM_DEV-1 -> every read returns 0, irq_req=0, dev_out_valid=0.
2. Ch1: CSR write 8'h31 (IE, ENA, PRI=1). dev_in_valid with 8'hA5 -> CSR reads 8'h35 and irq_req=1, irq_vect=1. Then a data read returns A5, after which the CSR reads 8'h31.
3. Ch1 input: two dev_in_valid bytes (11, 22) without a read -> CSR[3]=1 and data=22. A CSR write of 8'h08 then clears OF.
4. Ch2 output: CSR write 8'h12 -> DBA=1. Data write 8'h5A -> dev_out_valid=1, dev_out_data=5A, DBA=0. dev_out_ready held low for 3 cycles, then high -> DBA=1 one cycle after the handshake.
5. Ch0 (PRI=2) and ch3 (PRI=5) become pending in the same cycle -> irq_vect=3, irq_pri=5. irq_ack -> irq_vect=0, irq_pri=2. A second irq_ack -> irq_req=0.
6. Input dev_in_valid coincident with a data read, and Reset_n low during a pending output -> the read returns the old byte and DBA stays 1. After reset, all outputs are 0 and dev_out_valid=0.
